// File: rtl/jtpopeye_rom_pkg.sv
// Shared definitions for the jtpopeye ROM read arbiter.
// Holds the arbiter state encoding, the SDRAM data width and a helper that
// sizes channel-index fields (at least one bit, even for a single channel).
package jtpopeye_rom_pkg;

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic int unsigned chw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtpopeye_rom_slot.sv
// Per-channel return slot: holds the data word and ok flag for one ROM client.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   downloading      ROM download in progress: clears ok (and the cache)
//   cs, addr         client request level and word address
//   fill, fill_data  arbiter write strobe (already address-qualified) and data
//   ok, data         registered valid flag and data for the current address
// Optional feature: JTPOPEYE_ROMARB_CACHE_EN turns the single entry into a
// 4-entry direct-mapped cache (index addr[1:0], tag addr[AW-1:2]).
module jtpopeye_rom_slot
    import jtpopeye_rom_pkg::*;
#(
    parameter int unsigned AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [DW-1:0] fill_data,
    output logic          ok,
    output logic [DW-1:0] data
);

    logic          ok_q, ok_d;
    logic [DW-1:0] data_q, data_d;

`ifdef JTPOPEYE_ROMARB_CACHE_EN
    localparam int unsigned TGW = AW - 2;

    logic [3:0]     vld_q, vld_d;
    logic [TGW-1:0] tag_q [4];
    logic [TGW-1:0] tag_d [4];
    logic [DW-1:0]  mem_q [4];
    logic [DW-1:0]  mem_d [4];
    logic [1:0]     ix;

    assign ix = addr[1:0];

    // A hit re-validates ok one cycle after the address changes; fills win.
    always_comb begin
        vld_d  = vld_q;
        tag_d  = tag_q;
        mem_d  = mem_q;
        ok_d   = cs && vld_q[ix] && (tag_q[ix] == addr[AW-1:2]);
        data_d = ok_d ? mem_q[ix] : data_q;
        if (downloading) begin
            vld_d = '0;
            ok_d  = 1'b0;
        end else if (fill) begin
            vld_d[ix] = 1'b1;
            tag_d[ix] = addr[AW-1:2];
            mem_d[ix] = fill_data;
            ok_d      = 1'b1;
            data_d    = fill_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_q   <= 1'b0;
            data_q <= '0;
            vld_q  <= '0;
            for (int e = 0; e < 4; e++) begin
                tag_q[e] <= '0;
                mem_q[e] <= '0;
            end
        end else begin
            ok_q   <= ok_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            tag_q  <= tag_d;
            mem_q  <= mem_d;
        end
    end
`else
    logic [AW-1:0] tag_q, tag_d;

    // ok survives only while the address matches the filled one and cs holds;
    // returning to an old address still needs a new fetch.
    always_comb begin
        ok_d   = ok_q && cs && (addr == tag_q);
        data_d = data_q;
        tag_d  = tag_q;
        if (downloading) begin
            ok_d = 1'b0;
        end else if (fill) begin
            ok_d   = 1'b1;
            data_d = fill_data;
            tag_d  = addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_q   <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            ok_q   <= ok_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end
`endif

    assign ok   = ok_q;
    assign data = data_q;

endmodule

// File: rtl/jtpopeye_rom_arb.sv
// N-channel round-robin SDRAM ROM read arbiter.
// One 32-bit read is outstanding at a time; results return to the granted
// channel's slot only if its address is still the one that was issued.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   downloading           ROM download in progress: blocks grants, clears ok/ready
//   ch_cs/ch_addr         per-channel request level and address (CH*AW packed)
//   ch_data/ch_ok         per-channel returned data (CH*32 packed) and valid
//   sdram_re/sdram_addr   toggle-per-request strobe and request address
//   sdram_rdy/data_read   one-cycle completion pulse and read data
//   ready                 download finished and first fetch completed
// Optional feature: JTPOPEYE_ROMARB_CACHE_EN (per-channel 4-entry cache in
// jtpopeye_rom_slot).
module jtpopeye_rom_arb
    import jtpopeye_rom_pkg::*;
#(
    parameter int unsigned CH   = 2,
    parameter int unsigned AW   = 22,
    parameter int unsigned TOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             downloading,
    input  logic [CH-1:0]    ch_cs,
    input  logic [CH*AW-1:0] ch_addr,
    output logic [CH*DW-1:0] ch_data,
    output logic [CH-1:0]    ch_ok,
    output logic             sdram_re,
    output logic [AW-1:0]    sdram_addr,
    input  logic             sdram_rdy,
    input  logic [DW-1:0]    data_read,
    output logic             ready
);

    localparam int unsigned CHW = chw(CH);
    localparam int unsigned TW  = $clog2(TOUT + 1);

    state_t          state_q, state_d;
    logic [CHW-1:0]  gnt_q, gnt_d;
    logic [CHW-1:0]  rr_q, rr_d;
    logic [TW-1:0]   tout_q, tout_d;
    logic            re_q, re_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            ready_q, ready_d;

    logic [AW-1:0]   addr_a [CH];
    logic [CH-1:0]   req_c;
    logic [CHW-1:0]  pick_c;
    logic            found_c;
    logic            fill_c;
    int              idx_c;

    assign req_c = ch_cs & ~ch_ok & {CH{~downloading}};

    // Completion is kept only if the granted channel still wants this address.
    assign fill_c = (state_q == ST_WAIT) && sdram_rdy && !downloading &&
                    ch_cs[gnt_q] && (addr_a[gnt_q] == addr_q);

    // Round-robin pick: scan from rr_q upward, wrapping; reverse order so the
    // closest requester to the pointer is the one left standing.
    always_comb begin
        pick_c  = rr_q;
        found_c = 1'b0;
        idx_c   = 0;
        for (int k = int'(CH) - 1; k >= 0; k--) begin
            idx_c = int'(rr_q) + k;
            if (idx_c >= int'(CH)) idx_c = idx_c - int'(CH);
            if (req_c[CHW'(idx_c)]) begin
                pick_c  = CHW'(idx_c);
                found_c = 1'b1;
            end
        end
    end

    // Arbiter next-state and request outputs.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        tout_d  = tout_q;
        re_d    = re_q;
        addr_d  = addr_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    gnt_d   = pick_c;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (downloading) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = addr_a[gnt_q];
                    re_d    = ~re_q;
                    tout_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sdram_rdy) begin
                    rr_d    = (gnt_q == CHW'(CH - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = ST_IDLE;
                end else if (tout_q == TW'(TOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (downloading) ready_d = 1'b0;
        else if (fill_c) ready_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            tout_q  <= '0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            tout_q  <= tout_d;
            re_q    <= re_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
        end
    end

    for (genvar i = 0; i < int'(CH); i++) begin : g_slot
        assign addr_a[i] = ch_addr[i*AW +: AW];

        jtpopeye_rom_slot #(.AW(AW)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .downloading (downloading),
            .cs          (ch_cs[i]),
            .addr        (addr_a[i]),
            .fill        (fill_c && (gnt_q == CHW'(i))),
            .fill_data   (data_read),
            .ok          (ch_ok[i]),
            .data        (ch_data[i*DW +: DW])
        );
    end

    assign sdram_re   = re_q;
    assign sdram_addr = addr_q;
    assign ready      = ready_q;

endmodule
